mux_2_to_1_arbiter: RTL and testbench
=====================================

# mux_2_to_1_arbiter

Sequencing controller that shares one mux_2_to_1 datapath between two requesters. It grants the mux to one requester at a time using round-robin arbitration with a bounded burst length. It drives the mux select, and it registers the selected word into a single-entry output slot with a valid/ready handshake. It sits between two producer ports and one downstream consumer.

## Interface

Parameters:
- WIDTH, 8, data width of D0, D1 and Y.
- MAX_BURST, 4, maximum number of consecutive transfers from one requester while the other requester is waiting. Legal range is 1..15.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ0  input  1  requester 0 has a word on D0; held high until ACK0.
- D0  input  WIDTH  requester 0 data.
- ACK0  output  1  requester 0 word accepted this cycle (combinational).
- REQ1  input  1  requester 1 request.
- D1  input  WIDTH  requester 1 data.
- ACK1  output  1  requester 1 word accepted this cycle (combinational).
- S  output  1  mux select: 0 selects D0, 1 selects D1; registered.
- Y  output  WIDTH  output slot data; registered.
- YV  output  1  output slot valid; registered.
- YR  input  1  consumer ready.
- BUSY  output  1  high when the state is not IDLE (combinational from state).

## Operation

- **States:** IDLE, G0, G1.
- **Registers:** LAST is the last-granted requester; CNT is the transfer count in the current grant, 4 bits.
- **Reset values:**
  - State = IDLE, LAST = 1, CNT = 0.
  - S = 0, Y = 0, YV = 0.
  - As a result, requester 0 wins the first contention.
- **Slot free:** FREE = !YV || YR.
- **Transfer rule:** in Gx, when REQx && FREE:
  - ACKx = 1.
  - Y <= Dx, YV <= 1.
  - CNT <= CNT + 1.
- **ACK rules:**
  - ACK is never high in IDLE.
  - ACK is never high for the non-granted requester.
- **Slot drain:** when YV && YR and there is no transfer, YV <= 0 and Y holds its value.
- **IDLE:**
  - Only REQ0 high -> G0.
  - Only REQ1 high -> G1.
  - Both high -> the grant goes to the requester != LAST.
  - On entry to Gx: S <= x, LAST <= x, CNT <= 0.
- **Gx, evaluated every cycle after any transfer (y denotes the other requester):**
  - REQx low: go to Gy if REQy is high, otherwise go to IDLE.
  - Burst limit: the post-transfer CNT == MAX_BURST and REQy is high -> go to Gy, even though REQx is still high.
  - Burst limit with REQy low: CNT <= 0 and the state stays in Gx.
  - Otherwise the state stays in Gx.
- **Switch on Gx -> Gy:** S <= y, LAST <= y, CNT <= 0. No idle cycle is inserted.
- **Backpressure:** while FREE = 0, no ACK is issued and CNT does not advance, but grant transitions still follow the rules above.
- **Request protocol:** a requester must not drop REQ without ACK. Dropping REQ without ACK is not checked and is treated as withdrawal.

## Timing

- **Latency:**
  - Request to ACK: 1 cycle from IDLE, since the grant is registered first. Within a held grant it is 0 cycles.
  - ACK to YV: 1 cycle. Y and YV update on the same edge as the ACK'd transfer.
- **Throughput:** with YR held high, one word per cycle within a grant, including across grant switches.
- **Simultaneous events:**
  - Transfer and consumer drain in the same cycle: YV stays 1 and Y takes the new word.
  - Burst limit and REQx falling in the same cycle: follow the REQx-low rule. Both rules resolve to Gy when REQy is high.
- **CNT wrap:** CNT never exceeds MAX_BURST.
- **Reset mid-operation:**
  - A pending word in Y is discarded, YV = 0.
  - The in-progress grant is cancelled and no ACK is issued in the reset cycle.
  - Arbitration restarts with requester 0 priority.

## Test plan

- **Reset:** RST high for 2 cycles with REQ0 = REQ1 = 1 -> ACK0 = ACK1 = 0, YV = 0, Y = 0, S = 0, BUSY = 0.
- **Single requester:** REQ0 = 1 only, D0 = 8'hA5, YR = 1 -> BUSY and S = 0 next cycle, ACK0 the same cycle, then Y = A5 and YV = 1. Drop REQ0 -> IDLE, then YV = 0 one cycle after the drain.
- **Contention, MAX_BURST = 4:** REQ0 = REQ1 = 1 held, YR = 1, D0 = 8'h10, D1 = 8'h20 -> Y sequence 10,10,10,10,20,20,20,20,10,... and S toggles every 4 transfers with no gap cycle.
- **Backpressure:** grant G1 and YR = 0 with YV = 1 -> ACK1 stays 0 and Y is stable for 5 cycles. Raise YR -> ACK1 the same cycle and Y updates to the new D1 on the next edge.
- **Burst limit, no competitor:** REQ0 only, 9 transfers -> grant stays G0 and all 9 words are delivered consecutively.
- **Mid-burst reset:** reset after 2 transfers of a G1 burst with REQ0 = REQ1 = 1 -> after RST is released, the first grant is G0 (S = 0) and the first Y = D0.

Source files
------------

// File: rtl/mux_2_to_1_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between two requesters, with a bounded
// burst length per grant and a single-entry valid/ready output slot.
module mux_2_to_1_arbiter #(
   parameter int WIDTH     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             REQ0,
   input  logic [WIDTH-1:0] D0,
   output logic             ACK0,
   input  logic             REQ1,
   input  logic [WIDTH-1:0] D1,
   output logic             ACK1,
   output logic             S,
   output logic [WIDTH-1:0] Y,
   output logic             YV,
   input  logic             YR,
   output logic             BUSY
);

   typedef enum logic [1:0] {IDLE, G0, G1} state_t;

   localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

   state_t           state_q;
   logic             last_q;
   logic [3:0]       cnt_q;
   logic             sel_q;
   logic [WIDTH-1:0] slot_data_p1;
   logic             slot_vld_p1;

   logic             granted;
   logic             free;
   logic             req_own;
   logic             req_oth;
   logic             xfer;
   logic [3:0]       cnt_post;
   logic [WIDTH-1:0] mux_data;

   assign granted  = (state_q == G1);
   assign free     = !slot_vld_p1 || YR;
   // ACK is suppressed during reset so a cancelled grant never hands over a word.
   assign ACK0     = !RST && (state_q == G0) && REQ0 && free;
   assign ACK1     = !RST && (state_q == G1) && REQ1 && free;
   assign xfer     = ACK0 || ACK1;
   assign req_own  = granted ? REQ1 : REQ0;
   assign req_oth  = granted ? REQ0 : REQ1;
   assign cnt_post = xfer ? cnt_q + 4'd1 : cnt_q;
   assign mux_data = sel_q ? D1 : D0;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         cnt_q   <= 4'd0;
         sel_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (REQ0 && (!REQ1 || last_q)) begin
                  state_q <= G0;
                  sel_q   <= 1'b0;
                  last_q  <= 1'b0;
                  cnt_q   <= 4'd0;
               end else if (REQ1) begin
                  state_q <= G1;
                  sel_q   <= 1'b1;
                  last_q  <= 1'b1;
                  cnt_q   <= 4'd0;
               end
            end
            G0, G1: begin
               if (!req_own || (cnt_post == BURST_LIM)) begin
                  if (req_oth) begin
                     state_q <= granted ? G0 : G1;
                     sel_q   <= !granted;
                     last_q  <= !granted;
                  end else if (!req_own) begin
                     state_q <= IDLE;
                  end
                  cnt_q <= 4'd0;
               end else begin
                  cnt_q <= cnt_post;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

   // Output slot stage: a same-cycle drain and refill keeps the slot full.
   always_ff @(posedge CLK) begin
      if (RST) begin
         slot_data_p1 <= '0;
         slot_vld_p1  <= 1'b0;
      end else if (xfer) begin
         slot_data_p1 <= mux_data;
         slot_vld_p1  <= 1'b1;
      end else if (slot_vld_p1 && YR) begin
         slot_vld_p1  <= 1'b0;
      end
   end

   assign S    = sel_q;
   assign Y    = slot_data_p1;
   assign YV   = slot_vld_p1;
   assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_mux_2_to_1_arbiter.sv
// Bench for mux_2_to_1_arbiter: directed vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_mux_2_to_1_arbiter;

   localparam int WIDTH     = 8;
   localparam int MAX_BURST = 4;

   logic             CLK = 1'b0;
   logic             RST;
   logic             REQ0, REQ1, YR;
   logic [WIDTH-1:0] D0, D1;
   logic             ACK0, ACK1, S, YV, BUSY;
   logic [WIDTH-1:0] Y;

   int errors = 0;
   int checks = 0;

   mux_2_to_1_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0(REQ0), .D0(D0), .ACK0(ACK0),
      .REQ1(REQ1), .D1(D1), .ACK1(ACK1),
      .S(S), .Y(Y), .YV(YV), .YR(YR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst, r0, r1;
      logic [7:0] d0, d1;
      logic       yr;
      logic       a0, a1, s, yv;
      logic [7:0] y;
      logic       busy;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic rst, r0, r1, input logic [7:0] d0, d1,
                               input logic yr, a0, a1, s, yv, input logic [7:0] y,
                               input logic busy);
      vec_t v;
      v.rst = rst; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.yr = yr;
      v.a0 = a0; v.a1 = a1; v.s = s; v.yv = yv; v.y = y; v.busy = busy;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, r0, r1, input logic [7:0] d0, d1, input logic yr);
      RST = rst; REQ0 = r0; REQ1 = r1; D0 = d0; D1 = d1; YR = yr;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 8'h00, 8'h00, 1);
      tick();
      RST = 0;
   endtask

   // Reference model: who owns the mux, how many words it has moved, and the slot as a queue.
   int         owner;
   int         last_m;
   int         run;
   logic [7:0] slot_q [$];
   logic [7:0] y_m;
   logic       s_m;

   task automatic model_reset();
      owner = -1; last_m = 1; run = 0; slot_q.delete(); y_m = 8'h00; s_m = 1'b0;
   endtask

   task automatic model_grant(input int who);
      owner = who; last_m = who; s_m = (who == 1); run = 0;
   endtask

   task automatic model_step(input logic rst, input logic [1:0] req, input logic [7:0] d0,
                             input logic [7:0] d1, input logic yr, input logic [1:0] ack);
      int other;
      if (rst) begin
         model_reset();
         return;
      end
      if (slot_q.size() != 0 && yr) void'(slot_q.pop_front());
      if (ack != 2'b00) begin
         y_m = ack[0] ? d0 : d1;
         slot_q.push_back(y_m);
         run++;
      end
      if (owner < 0) begin
         if (req == 2'b11) model_grant(1 - last_m);
         else if (req[0]) model_grant(0);
         else if (req[1]) model_grant(1);
      end else begin
         other = 1 - owner;
         if (!req[owner]) begin
            if (req[other]) model_grant(other);
            else begin owner = -1; run = 0; end
         end else if (run == MAX_BURST) begin
            if (req[other]) model_grant(other);
            else run = 0;
         end
      end
   endtask

   initial begin
      drive(1, 1, 1, 8'h00, 8'h00, 1);
      tick();

      //            rst r0 r1 d0     d1     yr a0 a1 s  yv y      busy
      tbl[0]  = mk(1, 1, 1, 8'hA5, 8'h5A, 1, 0, 0, 0, 0, 8'h00, 0);
      tbl[1]  = mk(1, 1, 1, 8'hA5, 8'h5A, 1, 0, 0, 0, 0, 8'h00, 0);
      tbl[2]  = mk(0, 1, 0, 8'hA5, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0);
      tbl[3]  = mk(0, 1, 0, 8'hA5, 8'h00, 1, 1, 0, 0, 0, 8'h00, 1);
      tbl[4]  = mk(0, 0, 0, 8'hA5, 8'h00, 1, 0, 0, 0, 1, 8'hA5, 1);
      tbl[5]  = mk(0, 0, 0, 8'hA5, 8'h00, 1, 0, 0, 0, 0, 8'hA5, 0);
      tbl[6]  = mk(1, 1, 1, 8'h10, 8'h20, 1, 0, 0, 0, 0, 8'hA5, 0);
      tbl[7]  = mk(0, 1, 1, 8'h10, 8'h20, 1, 0, 0, 0, 0, 8'h00, 0);
      tbl[8]  = mk(0, 1, 1, 8'h10, 8'h20, 1, 1, 0, 0, 0, 8'h00, 1);
      tbl[9]  = mk(0, 1, 1, 8'h10, 8'h20, 1, 1, 0, 0, 1, 8'h10, 1);
      tbl[10] = mk(0, 1, 1, 8'h10, 8'h20, 1, 1, 0, 0, 1, 8'h10, 1);
      tbl[11] = mk(0, 1, 1, 8'h10, 8'h20, 1, 1, 0, 0, 1, 8'h10, 1);
      tbl[12] = mk(0, 1, 1, 8'h10, 8'h20, 1, 0, 1, 1, 1, 8'h10, 1);
      tbl[13] = mk(0, 1, 1, 8'h10, 8'h20, 1, 0, 1, 1, 1, 8'h20, 1);
      tbl[14] = mk(0, 1, 1, 8'h10, 8'h20, 1, 0, 1, 1, 1, 8'h20, 1);
      tbl[15] = mk(0, 1, 1, 8'h10, 8'h20, 1, 0, 1, 1, 1, 8'h20, 1);
      tbl[16] = mk(0, 1, 1, 8'h10, 8'h20, 1, 1, 0, 0, 1, 8'h20, 1);
      tbl[17] = mk(0, 1, 1, 8'h10, 8'h20, 1, 1, 0, 0, 1, 8'h10, 1);

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].rst, tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1, tbl[i].yr);
         @(negedge CLK);
         chk($sformatf("tbl%0d_ack0", i), 32'(ACK0), 32'(tbl[i].a0));
         chk($sformatf("tbl%0d_ack1", i), 32'(ACK1), 32'(tbl[i].a1));
         chk($sformatf("tbl%0d_s", i),    32'(S),    32'(tbl[i].s));
         chk($sformatf("tbl%0d_yv", i),   32'(YV),   32'(tbl[i].yv));
         chk($sformatf("tbl%0d_y", i),    32'(Y),    32'(tbl[i].y));
         chk($sformatf("tbl%0d_busy", i), 32'(BUSY), 32'(tbl[i].busy));
         tick();
      end

      // Backpressure on a G1 grant with a full slot.
      do_reset();
      drive(0, 0, 1, 8'h00, 8'h31, 1);
      tick();
      @(negedge CLK);
      chk("bp_grant_s", 32'(S), 32'd1);
      chk("bp_first_ack1", 32'(ACK1), 32'd1);
      tick();
      drive(0, 0, 1, 8'h00, 8'h32, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk($sformatf("bp_hold%0d_ack1", k), 32'(ACK1), 32'd0);
         chk($sformatf("bp_hold%0d_y", k), 32'(Y), 32'h31);
         chk($sformatf("bp_hold%0d_yv", k), 32'(YV), 32'd1);
         tick();
      end
      YR = 1;
      @(negedge CLK);
      chk("bp_release_ack1", 32'(ACK1), 32'd1);
      tick();
      chk("bp_release_y", 32'(Y), 32'h32);
      drive(0, 0, 0, 8'h00, 8'h00, 1);
      tick();
      tick();

      // Nine back-to-back words from a lone requester across the burst limit.
      do_reset();
      drive(0, 1, 0, 8'h40, 8'h00, 1);
      tick();
      for (int k = 0; k < 9; k++) begin
         D0 = 8'(8'h40 + k);
         @(negedge CLK);
         chk($sformatf("solo%0d_ack0", k), 32'(ACK0), 32'd1);
         chk($sformatf("solo%0d_s", k), 32'(S), 32'd0);
         tick();
         chk($sformatf("solo%0d_y", k), 32'(Y), 32'(8'h40 + k));
         chk($sformatf("solo%0d_yv", k), 32'(YV), 32'd1);
      end
      drive(0, 0, 0, 8'h00, 8'h00, 1);
      tick();
      tick();

      // Reset in the middle of a G1 burst.
      do_reset();
      drive(0, 0, 1, 8'h66, 8'h77, 1);
      tick();
      REQ0 = 1;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         chk($sformatf("mr_burst%0d_ack1", k), 32'(ACK1), 32'd1);
         tick();
      end
      RST = 1;
      @(negedge CLK);
      chk("mr_rst_ack0", 32'(ACK0), 32'd0);
      chk("mr_rst_ack1", 32'(ACK1), 32'd0);
      tick();
      chk("mr_rst_yv", 32'(YV), 32'd0);
      chk("mr_rst_y", 32'(Y), 32'd0);
      RST = 0;
      @(negedge CLK);
      chk("mr_idle_busy", 32'(BUSY), 32'd0);
      tick();
      @(negedge CLK);
      chk("mr_grant_s", 32'(S), 32'd0);
      chk("mr_grant_ack0", 32'(ACK0), 32'd1);
      chk("mr_grant_ack1", 32'(ACK1), 32'd0);
      tick();
      chk("mr_first_y", 32'(Y), 32'h66);
      chk("mr_first_yv", 32'(YV), 32'd1);

      // Randomized traffic against the reference model.
      do_reset();
      model_reset();
      begin
         logic       r0, r1, yr, rr;
         logic [7:0] d0, d1;
         logic [1:0] ea;
         r0 = 0; r1 = 0; d0 = 0; d1 = 0;
         for (int c = 0; c < 600; c++) begin
            rr = ($urandom_range(0, 99) == 0);
            yr = ($urandom_range(0, 2) != 0);
            drive(rr, r0, r1, d0, d1, yr);
            ea[0] = !rr && owner == 0 && r0 && (slot_q.size() == 0 || yr);
            ea[1] = !rr && owner == 1 && r1 && (slot_q.size() == 0 || yr);
            @(negedge CLK);
            chk($sformatf("rnd%0d_ack0", c), 32'(ACK0), 32'(ea[0]));
            chk($sformatf("rnd%0d_ack1", c), 32'(ACK1), 32'(ea[1]));
            chk($sformatf("rnd%0d_s", c), 32'(S), 32'(s_m));
            chk($sformatf("rnd%0d_yv", c), 32'(YV), 32'(slot_q.size() != 0));
            chk($sformatf("rnd%0d_y", c), 32'(Y), 32'(y_m));
            chk($sformatf("rnd%0d_busy", c), 32'(BUSY), 32'(owner >= 0));
            tick();
            model_step(rr, {r1, r0}, d0, d1, yr, ea);
            if (ea[0]) begin r0 = $urandom_range(0, 1); d0 = 8'($urandom); end
            else if (!r0) begin r0 = ($urandom_range(0, 2) == 0); d0 = 8'($urandom); end
            if (ea[1]) begin r1 = $urandom_range(0, 1); d1 = 8'($urandom); end
            else if (!r1) begin r1 = ($urandom_range(0, 2) == 0); d1 = 8'($urandom); end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
